// File: rtl/fixed_decode_param_if.sv
// Handshake/control bundle for fixed_decode_param.
// master = block feeding residuals / consuming samples, slave = decoder.
interface fixed_decode_param_if #(
    parameter int SAMPLE_W = 16,
    parameter int BLOCK_W  = 16
);
    logic                iStart;
    logic [2:0]          iOrder;
    logic [BLOCK_W-1:0]  iBlockSize;
    logic [SAMPLE_W-1:0] iResidual;
    logic                iValid;
    logic                oReady;
    logic [SAMPLE_W-1:0] oData;
    logic                oValid;
    logic                iReady;
    logic [BLOCK_W-1:0]  oSamplesOut;
    logic                oDone;
    logic                oErr;

    modport master (
        output iStart, iOrder, iBlockSize, iResidual, iValid, iReady,
        input  oReady, oData, oValid, oSamplesOut, oDone, oErr
    );

    modport slave (
        input  iStart, iOrder, iBlockSize, iResidual, iValid, iReady,
        output oReady, oData, oValid, oSamplesOut, oDone, oErr
    );
endinterface

// File: rtl/fixed_decode_param.sv
// Fixed-polynomial (order 0..4) predictor decoder.
// Warm-up samples pass through; afterwards each residual is added to a
// binomial extrapolation of the last `order` outputs.
// Optional macro FIXED_DECODE_SAT_EN: clamp predicted sums to the signed
// SAMPLE_W range instead of wrapping.
module fixed_decode_param #(
    parameter int SAMPLE_W = 16,
    parameter int BLOCK_W  = 16,
    parameter int ACC_W    = SAMPLE_W + 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    fixed_decode_param_if.slave  bus
);

`ifdef FIXED_DECODE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WARMUP, DECODE, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]                 order_q;
    logic [BLOCK_W-1:0]         bsize_q;
    logic [BLOCK_W-1:0]         in_cnt;
    logic [BLOCK_W-1:0]         out_cnt;
    logic signed [SAMPLE_W-1:0] s1, s2, s3, s4;
    logic [SAMPLE_W-1:0]        data_q;
    logic                       valid_q;
    logic                       err_q;

    logic                       start_ok;
    logic                       ready;
    logic                       xfer_in;
    logic                       xfer_out;
    logic                       last_warm;
    logic                       last_out;
    logic signed [ACC_W-1:0]    r_x, s1_x, s2_x, s3_x, s4_x;
    logic signed [ACC_W-1:0]    acc;
    logic [SAMPLE_W-1:0]        pred;
    logic [SAMPLE_W-1:0]        sample;

    assign start_ok  = (state == IDLE) && bus.iStart;
    // Output register may be refilled when empty or draining this cycle.
    assign ready     = ((state == WARMUP) || (state == DECODE)) &&
                       (!valid_q || bus.iReady) && (in_cnt < bsize_q);
    assign xfer_in   = bus.iValid && ready;
    assign xfer_out  = valid_q && bus.iReady;
    assign last_warm = xfer_in  && ((in_cnt  + BLOCK_W'(1)) == BLOCK_W'(order_q));
    assign last_out  = xfer_out && ((out_cnt + BLOCK_W'(1)) == bsize_q);

    assign r_x  = ACC_W'($signed(bus.iResidual));
    assign s1_x = ACC_W'(s1);
    assign s2_x = ACC_W'(s2);
    assign s3_x = ACC_W'(s3);
    assign s4_x = ACC_W'(s4);

    // Binomial extrapolation built from shifts/adds; ACC_W holds the worst case.
    always_comb begin
        acc = r_x;
        case (order_q)
            3'd1: acc = r_x + s1_x;
            3'd2: acc = r_x + (s1_x <<< 1) - s2_x;
            3'd3: acc = r_x + (s1_x <<< 1) + s1_x - (s2_x <<< 1) - s2_x + s3_x;
            3'd4: acc = r_x + (s1_x <<< 2) - (s2_x <<< 2) - (s2_x <<< 1)
                        + (s3_x <<< 2) - s4_x;
            default: acc = r_x;
        endcase
    end

    // Reduce the accumulator to SAMPLE_W: clamp or two's-complement wrap.
    always_comb begin
        pred = acc[SAMPLE_W-1:0];
        if (SAT_EN && (acc > MAXV))
            pred = MAXV[SAMPLE_W-1:0];
        else if (SAT_EN && (acc < MINV))
            pred = MINV[SAMPLE_W-1:0];
    end

    assign sample = (state == WARMUP) ? bus.iResidual : pred;

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: illegal order and empty blocks go straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    if ((bus.iOrder > 3'd4) || (bus.iBlockSize == '0))
                        state_nx = DONE;
                    else if (bus.iOrder == 3'd0)
                        state_nx = DECODE;
                    else
                        state_nx = WARMUP;
                end
            end
            // Short blocks (size < order) finish without leaving warm-up.
            WARMUP: begin
                if (last_out)       state_nx = DONE;
                else if (last_warm) state_nx = DECODE;
            end
            DECODE:  if (last_out) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Block parameters, counters, error flag and history.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            order_q <= '0;
            bsize_q <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_q   <= 1'b0;
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            s4      <= '0;
        end else if (start_ok) begin
            order_q <= bus.iOrder;
            bsize_q <= bus.iBlockSize;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_q   <= (bus.iOrder > 3'd4);
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            s4      <= '0;
        end else begin
            if (xfer_in) begin
                in_cnt <= in_cnt + BLOCK_W'(1);
                s4     <= s3;
                s3     <= s2;
                s2     <= s1;
                s1     <= sample;
            end
            if (xfer_out) out_cnt <= out_cnt + BLOCK_W'(1);
        end
    end

    // Output register: load on input transfer, hold until downstream takes it.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (xfer_in) begin
            data_q  <= sample;
            valid_q <= 1'b1;
        end else if (xfer_out) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.oReady      = ready;
    assign bus.oData       = data_q;
    assign bus.oValid      = valid_q;
    assign bus.oSamplesOut = out_cnt;
    assign bus.oDone       = (state == DONE);
    assign bus.oErr        = err_q;

endmodule

// File: doc/fixed_decode_param.md
FIXED_DECODE_PARAM -- requirements
Module: fixed_decode_param

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning width of residual and output samples.
REQ-002 SHALL have parameter BLOCK_W, default 16, meaning width of block-size field and sample counter.
REQ-003 SHALL have parameter ACC_W, default SAMPLE_W+4, meaning internal prediction accumulator width.
REQ-004 SHALL have port iClk, input, 1, the single clock.
REQ-005 SHALL have port iRst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iStart, input, 1, one-cycle pulse that begins a block (accepted in IDLE only).
REQ-007 SHALL have port iOrder, input, 3, fixed predictor order 0..4, sampled at iStart.
REQ-008 SHALL have port iBlockSize, input, BLOCK_W, samples in block, sampled at iStart.
REQ-009 SHALL have port iResidual, input, SAMPLE_W, signed warm-up sample or residual.
REQ-010 SHALL have port iValid, input, 1, iResidual valid.
REQ-011 SHALL have port oReady, output, 1, decoder accepts iResidual this cycle.
REQ-012 SHALL have port oData, output, SAMPLE_W, signed reconstructed sample.
REQ-013 SHALL have port oValid, output, 1, oData valid.
REQ-014 SHALL have port iReady, input, 1, downstream accepts oData.
REQ-015 SHALL have port oSamplesOut, output, BLOCK_W, count of samples delivered in current block.
REQ-016 SHALL have port oDone, output, 1, one-cycle pulse after final sample delivered.
REQ-017 SHALL have port oErr, output, 1, sticky until next accepted iStart; set on illegal order.

Function
REQ-018 SHALL implement states IDLE, WARMUP, DECODE, DONE; IDLE->WARMUP on iStart (order 1..4), IDLE->DECODE on iStart (order 0), WARMUP->DECODE after iOrder samples accepted, DECODE->DONE when oSamplesOut reaches iBlockSize, DONE->IDLE next cycle.
REQ-019 SHALL transfer input on iValid && oReady; oReady = (state is WARMUP or DECODE) && (!oValid || iReady) && input count < block size.
REQ-020 SHALL pass warm-up samples to oData unchanged.
REQ-021 SHALL compute in DECODE: order0 r; order1 r+s1; order2 r+2s1-s2; order3 r+3s1-3s2+s3; order4 r+4s1-6s2+4s3-s4; s1..s4 most recent outputs, sign-extended to ACC_W.
REQ-022 SHALL register oData/oValid one cycle after input transfer (latency 1); oValid holds with stable oData until iReady.
REQ-023 SHALL shift history (s4<-s3<-s2<-s1<-new) on every input transfer, storing the SAMPLE_W output value.
REQ-024 SHALL increment oSamplesOut on each output transfer (oValid && iReady); clear to 0 on accepted iStart.
REQ-025 SHALL, for iBlockSize < iOrder, emit all samples as warm-up then DONE.
REQ-026 SHALL, for iBlockSize = 0, go IDLE->DONE directly with no output, pulsing oDone.
REQ-027 SHALL, for iOrder 5..7, set oErr, go to DONE, emit no samples.
REQ-028 SHALL ignore iStart outside IDLE; SHALL ignore iValid while oReady is low.
REQ-029 SHALL clear history at each accepted iStart.

Reset
REQ-030 SHALL on iRst low, immediately and regardless of clock: state IDLE, oData 0, oValid 0, oReady 0, oSamplesOut 0, oDone 0, oErr 0, history 0.
REQ-031 SHALL abandon any block in progress on reset; first cycle after release is IDLE.

Configuration
REQ-032 SHALL use macro FIXED_DECODE_SAT_EN: defined -> predicted sum outside SAMPLE_W signed range is clamped to max/min; undefined -> sum truncated to low SAMPLE_W bits (two's-complement wrap).

Verification
REQ-033 SHALL verify order 4, block 16, warm-up 1,2,3,4, residuals all 0, iReady=1 -> oData 1..16, oDone after 16th, oSamplesOut=16.
REQ-034 SHALL verify order 2, block 5, inputs 10,12,0,0,-3 -> oData 10,12,14,16,15.
REQ-035 SHALL verify iReady low for 3 cycles mid-block -> oData stable, oReady low, no sample lost or duplicated.
REQ-036 SHALL verify order 1, SAMPLE_W 16, warm-up 32767, residual 1 -> 32767 with FIXED_DECODE_SAT_EN, -32768 without.
REQ-037 SHALL verify iOrder 6 -> oErr 1, oDone pulse, zero outputs; iBlockSize 0 -> oDone pulse, zero outputs.
REQ-038 SHALL verify iRst low during DECODE at sample 7 -> all outputs 0 asynchronously; new iStart decodes correctly from empty history.
